// File: rtl/acia_port_arbiter.sv
// Round-robin arbiter that shares one 6800-style ACIA register port between two
// requesters. The selected access is held across the E fall that commits it.
module acia_port_arbiter #(
  parameter int E_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E,
  input  logic       a_req,
  input  logic       a_rs,
  input  logic       a_rw,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic       a_err,
  input  logic       b_req,
  input  logic       b_rs,
  input  logic       b_rw,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic       b_err,
  output logic [7:0] rdata,
  output logic       acia_sel,
  output logic       acia_rs,
  output logic       acia_rw,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(E_TIMEOUT - 1);

  state_t     state;
  logic       e_d;
  logic       last_b;
  logic       grant_b;
  logic [7:0] cnt;

  logic       e_fall;
  logic       any_req;
  logic       pick_b;
  logic       pick_rs;
  logic       pick_rw;
  logic [7:0] pick_wdata;

  // Same falling-edge strobe the ACIA uses to commit an access
  assign e_fall = e_d & ~E;

  // Round-robin choice and the field set of the port that would win this cycle
  always_comb begin
    any_req = a_req | b_req;
    if (a_req && b_req) begin
      pick_b = ~last_b;
    end else begin
      pick_b = b_req;
    end
    if (pick_b) begin
      pick_rs    = b_rs;
      pick_rw    = b_rw;
      pick_wdata = b_wdata;
    end else begin
      pick_rs    = a_rs;
      pick_rw    = a_rw;
      pick_wdata = a_wdata;
    end
  end

  // Arbitration FSM; every output is a register written here
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      e_d      <= 1'b0;
      last_b   <= 1'b0;
      grant_b  <= 1'b0;
      cnt      <= 8'd0;
      acia_sel <= 1'b0;
      acia_rs  <= 1'b0;
      acia_rw  <= 1'b1;
      acia_din <= 8'd0;
      rdata    <= 8'd0;
      a_ack    <= 1'b0;
      a_err    <= 1'b0;
      b_ack    <= 1'b0;
      b_err    <= 1'b0;
    end else begin
      e_d <= E;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_b  <= pick_b;
            acia_rs  <= pick_rs;
            acia_rw  <= pick_rw;
            acia_din <= pick_wdata;
            acia_sel <= 1'b1;
            cnt      <= 8'd0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // A commit on the limit cycle still counts as a completed access
          if (e_fall) begin
            if (acia_rw) begin
              rdata <= acia_dout;
            end
            acia_sel <= 1'b0;
            a_ack    <= ~grant_b;
            b_ack    <= grant_b;
            state    <= DONE;
          end else if (cnt == CNT_LIMIT) begin
            acia_sel <= 1'b0;
            a_err    <= ~grant_b;
            b_err    <= grant_b;
            state    <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          a_ack  <= 1'b0;
          a_err  <= 1'b0;
          b_ack  <= 1'b0;
          b_err  <= 1'b0;
          last_b <= grant_b;
          state  <= IDLE;
        end
        default: begin
          acia_sel <= 1'b0;
          a_ack    <= 1'b0;
          a_err    <= 1'b0;
          b_ack    <= 1'b0;
          b_err    <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acia_port_arbiter.sv
// Bench for acia_port_arbiter: d0 uses the default timeout with a free-running
// 40-clk E; d1 uses E_TIMEOUT=16 with E placed by hand for the corner cases.
module tb_acia_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic e0 = 1'b0;
  logic e1 = 1'b0;

  logic       d0_a_req = 1'b0, d0_a_rs = 1'b0, d0_a_rw = 1'b1, d0_b_req = 1'b0, d0_b_rs = 1'b0, d0_b_rw = 1'b1;
  logic [7:0] d0_a_wd = 8'h00, d0_b_wd = 8'h00, d0_dout = 8'h00;
  logic       d0_a_ack, d0_a_err, d0_b_ack, d0_b_err, d0_sel, d0_rs, d0_rw;
  logic [7:0] d0_rdata, d0_din;

  logic       d1_a_req = 1'b0, d1_a_rs = 1'b0, d1_a_rw = 1'b1, d1_b_req = 1'b0, d1_b_rs = 1'b0, d1_b_rw = 1'b1;
  logic [7:0] d1_a_wd = 8'h00, d1_b_wd = 8'h00, d1_dout = 8'h00;
  logic       d1_a_ack, d1_a_err, d1_b_ack, d1_b_err, d1_sel, d1_rs, d1_rw;
  logic [7:0] d1_rdata, d1_din;

  int n_checks = 0;
  int n_fail = 0;
  int commits0 = 0;
  int ecnt = 0;

  acia_port_arbiter d0 (
    .clk(clk), .reset(reset), .E(e0),
    .a_req(d0_a_req), .a_rs(d0_a_rs), .a_rw(d0_a_rw), .a_wdata(d0_a_wd), .a_ack(d0_a_ack), .a_err(d0_a_err),
    .b_req(d0_b_req), .b_rs(d0_b_rs), .b_rw(d0_b_rw), .b_wdata(d0_b_wd), .b_ack(d0_b_ack), .b_err(d0_b_err),
    .rdata(d0_rdata), .acia_sel(d0_sel), .acia_rs(d0_rs), .acia_rw(d0_rw), .acia_din(d0_din), .acia_dout(d0_dout)
  );

  acia_port_arbiter #(.E_TIMEOUT(16)) d1 (
    .clk(clk), .reset(reset), .E(e1),
    .a_req(d1_a_req), .a_rs(d1_a_rs), .a_rw(d1_a_rw), .a_wdata(d1_a_wd), .a_ack(d1_a_ack), .a_err(d1_a_err),
    .b_req(d1_b_req), .b_rs(d1_b_rs), .b_rw(d1_b_rw), .b_wdata(d1_b_wd), .b_ack(d1_b_ack), .b_err(d1_b_err),
    .rdata(d1_rdata), .acia_sel(d1_sel), .acia_rs(d1_rs), .acia_rw(d1_rw), .acia_din(d1_din), .acia_dout(d1_dout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic       port_b;
    logic       rs;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] dout;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; step d0's E and count the commit the coming rising edge will see
  task automatic tick();
    logic e_old;
    @(negedge clk);
    e_old = e0;
    ecnt++;
    if (ecnt == 20) begin
      ecnt = 0;
      e0 = ~e0;
    end
    if (e_old && !e0 && d0_sel) commits0++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic got, held, stray, own, other;
    int c0;
    d0_dout = v.dout;
    if (v.port_b) begin
      d0_b_req = 1'b1; d0_b_rs = v.rs; d0_b_rw = v.rw; d0_b_wd = v.wdata;
    end else begin
      d0_a_req = 1'b1; d0_a_rs = v.rs; d0_a_rw = v.rw; d0_a_wd = v.wdata;
    end
    c0 = commits0;
    tick();
    check($sformatf("v%0d_sel_rise", idx), d0_sel, 1);
    check($sformatf("v%0d_fields", idx), {d0_rs, d0_rw, d0_din}, {v.rs, v.rw, v.wdata});
    got = 1'b0; held = 1'b1; stray = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      tick();
      own   = v.port_b ? d0_b_ack : d0_a_ack;
      other = v.port_b ? d0_a_ack : d0_b_ack;
      if (other || d0_a_err || d0_b_err) stray = 1'b1;
      if (own) got = 1'b1;
      else if (!d0_sel || {d0_rs, d0_rw, d0_din} !== {v.rs, v.rw, v.wdata}) held = 1'b0;
    end
    d0_a_req = 1'b0;
    d0_b_req = 1'b0;
    check($sformatf("v%0d_ack_seen", idx), got, 1);
    check($sformatf("v%0d_held", idx), held, 1);
    check($sformatf("v%0d_no_stray", idx), stray, 0);
    check($sformatf("v%0d_sel_drop", idx), d0_sel, 0);
    check($sformatf("v%0d_rdata", idx), d0_rdata, v.exp_rdata);
    check($sformatf("v%0d_commits", idx), commits0 - c0, 1);
    tick();
    check($sformatf("v%0d_ack_pulse", idx), {d0_a_ack, d0_b_ack}, 2'b00);
  endtask

  initial begin
    logic [3:0] exp_seq;
    logic [7:0] din_at_grant;
    logic       sel_prev, got, stray;
    int         grants, gap, k;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h96, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h5A, 8'h5A};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h83, 8'h83};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'hEE, 8'h83};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};

    // Reset values
    reset = 1'b1;
    repeat (3) tick();
    check("rst_d0", {d0_sel, d0_rs, d0_rw, d0_din, d0_rdata, d0_a_ack, d0_a_err, d0_b_ack, d0_b_err},
          {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0000});
    check("rst_d1", {d1_sel, d1_rs, d1_rw, d1_din, d1_rdata, d1_a_ack, d1_a_err, d1_b_ack, d1_b_err},
          {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0000});
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Contention: last served was B, so the tie goes A, B, A, B
    exp_seq = 4'b1010;
    d0_a_rs = 1'b0; d0_a_rw = 1'b0; d0_a_wd = 8'h11;
    d0_b_rs = 1'b1; d0_b_rw = 1'b0; d0_b_wd = 8'h22;
    d0_a_req = 1'b1; d0_b_req = 1'b1;
    grants = 0; gap = 0; sel_prev = 1'b0; din_at_grant = 8'h00;
    for (int w = 0; w < 400 && grants < 4; w++) begin
      tick();
      if (d0_sel && !sel_prev) begin
        din_at_grant = d0_din;
        if (grants > 0) check($sformatf("cont_gap%0d", grants), gap >= 2, 1);
      end
      gap = d0_sel ? 0 : gap + 1;
      sel_prev = d0_sel;
      if (d0_a_ack || d0_b_ack) begin
        check($sformatf("cont_port%0d", grants), d0_b_ack, exp_seq[grants]);
        check($sformatf("cont_excl%0d", grants), d0_a_ack & d0_b_ack, 0);
        check($sformatf("cont_din%0d", grants), din_at_grant, d0_b_ack ? 8'h22 : 8'h11);
        if (d0_b_ack) d0_b_req = 1'b0;
        else d0_a_req = 1'b0;
        grants++;
      end else begin
        d0_a_req = 1'b1;
        d0_b_req = 1'b1;
      end
    end
    d0_a_req = 1'b0;
    d0_b_req = 1'b0;
    check("cont_grants", grants, 4);
    repeat (3) tick();

    // Timeout on d1 with E stuck low, B waiting behind A
    d1_a_rs = 1'b0; d1_a_rw = 1'b0; d1_a_wd = 8'h44; d1_a_req = 1'b1;
    tick();
    check("to_sel_rise", d1_sel, 1);
    d1_b_rs = 1'b1; d1_b_rw = 1'b1; d1_b_wd = 8'h00; d1_dout = 8'hC3; d1_b_req = 1'b1;
    got = 1'b0; stray = 1'b0; k = 1;
    while (k < 40 && !got) begin
      tick();
      k++;
      if (d1_a_err) got = 1'b1;
      else if (d1_a_ack || d1_b_ack || d1_b_err) stray = 1'b1;
    end
    d1_a_req = 1'b0;
    check("to_err_cycle", k, 17);
    check("to_no_ack", {stray, d1_a_ack}, 2'b00);
    check("to_sel_drop", d1_sel, 0);
    k = 0;
    got = 1'b0;
    while (k < 10 && !got) begin
      tick();
      k++;
      if (d1_sel) got = 1'b1;
    end
    check("to_b_grant_delay", k, 2);
    check("to_b_fields", {d1_rs, d1_rw}, 2'b11);

    // Edge coincidence: E falls in the counter == E_TIMEOUT-1 cycle of B's access
    stray = 1'b0;
    for (int j = 0; j < 14; j++) begin
      tick();
      if (d1_a_ack || d1_a_err || d1_b_ack || d1_b_err || !d1_sel) stray = 1'b1;
    end
    e1 = 1'b1;
    tick();
    if (d1_a_ack || d1_a_err || d1_b_ack || d1_b_err || !d1_sel) stray = 1'b1;
    e1 = 1'b0;
    tick();
    d1_b_req = 1'b0;
    check("co_quiet_before", stray, 0);
    check("co_ack_no_err", {d1_b_ack, d1_b_err, d1_a_ack, d1_a_err}, 4'b1000);
    check("co_rdata", d1_rdata, 8'hC3);
    check("co_sel_drop", d1_sel, 0);
    tick();
    check("co_ack_pulse", d1_b_ack, 0);
    tick();

    // Reset in the middle of an access
    d1_a_rs = 1'b1; d1_a_rw = 1'b0; d1_a_wd = 8'h7E; d1_a_req = 1'b1;
    tick();
    check("rm_sel_rise", d1_sel, 1);
    repeat (2) tick();
    reset = 1'b1;
    d1_a_req = 1'b0;
    tick();
    check("rm_outputs", {d1_sel, d1_rs, d1_rw, d1_din, d1_rdata, d1_a_ack, d1_a_err, d1_b_ack, d1_b_err},
          {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0000});
    reset = 1'b0;
    stray = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (d1_a_ack || d1_a_err || d1_b_ack || d1_b_err || d1_sel) stray = 1'b1;
    end
    check("rm_no_completion", stray, 0);
    d1_a_req = 1'b1;
    tick();
    check("rm_idle_regrant", d1_sel, 1);
    d1_a_req = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
